// File: rtl/sync_fifo_flags.sv
// ---------------------------------------------------------------------------
// sync_fifo_flags
//
// Single-clock FIFO with level flags, threshold flags, an occupancy count
// and sticky overflow/underflow error flags.
//
// Optional feature macro: SYNC_FIFO_FWFT_EN
//   undefined : standard mode. read_data is loaded on the edge that accepts
//               a read, so there is one cycle of latency.
//   defined   : first-word-fall-through mode. read_data already shows the
//               oldest word whenever fifo_empty is 0, and read_en pops it.
//
// Parameters
//   RAM_WIDTH           data word width (1..256)
//   RAM_DEPTH           number of entries (power of two, >= 4)
//   ALMOST_FULL_THRESH  fifo_almost_full  = (fifo_count >= threshold)
//   ALMOST_EMPTY_THRESH fifo_almost_empty = (fifo_count <= threshold)
//
// Ports
//   clk               rising-edge clock
//   rst_n             asynchronous active-low reset
//   fifo_clr          synchronous flush (pointers, count, error flags)
//   write_en          write request
//   write_data        word to write
//   read_en           read request
//   read_data         word read out
//   fifo_empty        no words held
//   fifo_full         RAM_DEPTH words held
//   fifo_almost_empty count at or below ALMOST_EMPTY_THRESH
//   fifo_almost_full  count at or above ALMOST_FULL_THRESH
//   fifo_count        current fill level, 0..RAM_DEPTH
//   overflow          sticky: a write was attempted while full
//   underflow         sticky: a read was attempted while empty
// ---------------------------------------------------------------------------
module sync_fifo_flags #(
   parameter int RAM_WIDTH           = 8,
   parameter int RAM_DEPTH           = 256,
   parameter int ALMOST_FULL_THRESH  = RAM_DEPTH - 4,
   parameter int ALMOST_EMPTY_THRESH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         fifo_clr,
   input  logic                         write_en,
   input  logic [RAM_WIDTH-1:0]         write_data,
   input  logic                         read_en,
   output logic [RAM_WIDTH-1:0]         read_data,
   output logic                         fifo_empty,
   output logic                         fifo_full,
   output logic                         fifo_almost_empty,
   output logic                         fifo_almost_full,
   output logic [$clog2(RAM_DEPTH):0]   fifo_count,
   output logic                         overflow,
   output logic                         underflow
);

   localparam int ADDR_WIDTH = $clog2(RAM_DEPTH);
   localparam int PTR_W      = ADDR_WIDTH + 1;

   localparam logic [PTR_W-1:0] ONE         = PTR_W'(1);
   localparam logic [PTR_W-1:0] DEPTH_LEVEL = PTR_W'(RAM_DEPTH);
   localparam logic [PTR_W-1:0] AF_LEVEL    = PTR_W'(ALMOST_FULL_THRESH);
   localparam logic [PTR_W-1:0] AE_LEVEL    = PTR_W'(ALMOST_EMPTY_THRESH);

   logic [RAM_WIDTH-1:0] ram_q [RAM_DEPTH];

   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]     count_q, count_d;
   logic [RAM_WIDTH-1:0] read_data_q, read_data_d;
   logic                 overflow_q, overflow_d;
   logic                 underflow_q, underflow_d;

   logic                 ram_we;
   logic                 wr_accept;
   logic                 rd_accept;

`ifdef SYNC_FIFO_FWFT_EN
   // The output register holds the oldest word; the RAM holds the rest.
   logic                 out_valid_q, out_valid_d;
   logic                 ram_empty;
   logic                 bypass;

   assign ram_empty  = (wr_ptr_q == rd_ptr_q);
   assign fifo_empty = ~out_valid_q;
   // The RAM never holds more than RAM_DEPTH-1 words here, so the pointer
   // pair cannot express "full"; the count (which includes the output
   // register) is the authoritative level.
   assign fifo_full  = (count_q == DEPTH_LEVEL);
`else
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   // Same slot but one lap apart.
   assign fifo_full  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                       (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
`endif

   assign fifo_almost_full  = (count_q >= AF_LEVEL);
   assign fifo_almost_empty = (count_q <= AE_LEVEL);

   assign wr_accept = write_en & ~fifo_full;
   assign rd_accept = read_en & ~fifo_empty;

   assign read_data  = read_data_q;
   assign fifo_count = count_q;
   assign overflow   = overflow_q;
   assign underflow  = underflow_q;

   // Next-state logic: flush wins over everything, otherwise accepted
   // reads/writes move the pointers, the count tracks the net change and
   // rejected requests latch the sticky error flags.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      read_data_d = read_data_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      ram_we      = 1'b0;
`ifdef SYNC_FIFO_FWFT_EN
      out_valid_d = out_valid_q;
      bypass      = 1'b0;
`endif

      if (fifo_clr) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
`ifdef SYNC_FIFO_FWFT_EN
         out_valid_d = 1'b0;
`endif
      end else begin
         if (write_en && fifo_full) begin
            overflow_d = 1'b1;
         end
         if (read_en && fifo_empty) begin
            underflow_d = 1'b1;
         end

`ifdef SYNC_FIFO_FWFT_EN
         // Refill the output register whenever it is free or being popped:
         // from the RAM if it has data, otherwise straight from a write so
         // the first word is visible one cycle after it is written.
         if (!out_valid_q || rd_accept) begin
            if (!ram_empty) begin
               read_data_d = ram_q[rd_ptr_q[ADDR_WIDTH-1:0]];
               rd_ptr_d    = rd_ptr_q + ONE;
               out_valid_d = 1'b1;
            end else if (wr_accept) begin
               read_data_d = write_data;
               out_valid_d = 1'b1;
               bypass      = 1'b1;
            end else begin
               out_valid_d = 1'b0;
            end
         end
         if (wr_accept && !bypass) begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + ONE;
         end
`else
         if (wr_accept) begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + ONE;
         end
         if (rd_accept) begin
            read_data_d = ram_q[rd_ptr_q[ADDR_WIDTH-1:0]];
            rd_ptr_d    = rd_ptr_q + ONE;
         end
`endif

         case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + ONE;
            2'b01:   count_d = count_q - ONE;
            default: count_d = count_q;
         endcase
      end
   end

   // State registers, cleared immediately by rst_n.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         read_data_q <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
`ifdef SYNC_FIFO_FWFT_EN
         out_valid_q <= 1'b0;
`endif
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         read_data_q <= read_data_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
`ifdef SYNC_FIFO_FWFT_EN
         out_valid_q <= out_valid_d;
`endif
      end
   end

   // Storage array; deliberately not reset or flushed so it maps onto RAM.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= write_data;
      end
   end

endmodule
